data_mem_sequencer: RTL and testbench

//  Multi-cycle load/store sequencer between the core and the data-memory bus.

---
 rtl/data_mem_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_data_mem_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sequencer.sv
// data_mem_sequencer
//   Multi-cycle load/store sequencer between the core and the data-memory bus.
//   Accepts one RV32I load/store, checks alignment, issues a single
//   word-aligned bus transaction with byte enables, waits for ack or timeout,
//   then returns extracted / sign-extended load data.
//
// Ports
//   iCLK, iRST        clock, synchronous active-high reset
//   iReq              core request (sampled only while idle)
//   iWrite            1 = store, 0 = load
//   iFunct3           RV32I load/store funct3
//   iAddress          byte address
//   iWriteData        store data (low bits used for SB/SH)
//   oBusy             high whenever an access is in progress
//   oDone             one-cycle completion pulse
//   oLoadData         load result, valid with oDone, held until next load
//   oMisaligned       with oDone: access aborted, misaligned
//   oTimeout          with oDone: access aborted, no ack
//   oMemReq           bus request
//   oMemWrite         bus write strobe
//   oMemAddr          word address
//   oMemByteEn        byte-lane enables
//   oMemWdata         lane-replicated store data
//   iMemAck           bus ack, completes the transaction in the sampled cycle
//   iMemRdata         read word, valid with iMemAck
module data_mem_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iReq,
   input  logic        iWrite,
   input  logic [2:0]  iFunct3,
   input  logic [31:0] iAddress,
   input  logic [31:0] iWriteData,
   output logic        oBusy,
   output logic        oDone,
   output logic [31:0] oLoadData,
   output logic        oMisaligned,
   output logic        oTimeout,
   output logic        oMemReq,
   output logic        oMemWrite,
   output logic [31:0] oMemAddr,
   output logic [3:0]  oMemByteEn,
   output logic [31:0] oMemWdata,
   input  logic        iMemAck,
   input  logic [31:0] iMemRdata
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LP_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t         r_state;
   state_t         w_next;

   logic           r_write;
   logic [2:0]     r_funct3;
   logic [31:0]    r_addr;
   logic [31:0]    r_wdata;
   logic [CW-1:0]  r_cnt;
   logic [31:0]    r_load_data;
   logic           r_misal;
   logic           r_tmo;

   logic           w_half_in;
   logic           w_misal;
   logic           w_expire;
   logic [3:0]     w_byte_en;
   logic [31:0]    w_wdata;
   logic [7:0]     w_lane_byte;
   logic [15:0]    w_lane_half;
   logic [31:0]    w_load_val;

   // Alignment is judged on the live request so a bad access never reaches the bus.
   assign w_half_in = (iFunct3 == 3'b001) || (!iWrite && (iFunct3 == 3'b101));
   assign w_misal   = (w_half_in && iAddress[0]) ||
                      ((iFunct3 == 3'b010) && (iAddress[1:0] != 2'b00));

   // Last REQ cycle without ack; a zero budget disables the timeout entirely.
   assign w_expire  = (TIMEOUT_CYCLES != 0) && (r_state == S_REQ) &&
                      !iMemAck && (r_cnt == LP_LAST);

   assign oLoadData = r_load_data;

   always_comb begin
      w_byte_en = '0;
      w_wdata   = r_wdata;
      if (!r_write) begin
         w_byte_en = '1;
      end else begin
         case (r_funct3)
            3'b000: begin
               w_byte_en = 4'b0001 << r_addr[1:0];
               w_wdata   = {4{r_wdata[7:0]}};
            end
            3'b001: begin
               w_byte_en = r_addr[1] ? 4'b1100 : 4'b0011;
               w_wdata   = {2{r_wdata[15:0]}};
            end
            3'b010:  w_byte_en = '1;
            default: w_byte_en = '0;
         endcase
      end
   end

   always_comb begin
      w_lane_half = r_addr[1] ? iMemRdata[31:16] : iMemRdata[15:0];
      case (r_addr[1:0])
         2'd0:    w_lane_byte = iMemRdata[7:0];
         2'd1:    w_lane_byte = iMemRdata[15:8];
         2'd2:    w_lane_byte = iMemRdata[23:16];
         default: w_lane_byte = iMemRdata[31:24];
      endcase
      case (r_funct3)
         3'b000:  w_load_val = {{24{w_lane_byte[7]}}, w_lane_byte};
         3'b100:  w_load_val = {24'b0, w_lane_byte};
         3'b001:  w_load_val = {{16{w_lane_half[15]}}, w_lane_half};
         3'b101:  w_load_val = {16'b0, w_lane_half};
         3'b010:  w_load_val = iMemRdata;
         default: w_load_val = '0;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      oBusy       = 1'b0;
      oDone       = 1'b0;
      oMisaligned = 1'b0;
      oTimeout    = 1'b0;
      oMemReq     = 1'b0;
      oMemWrite   = 1'b0;
      oMemAddr    = '0;
      oMemByteEn  = '0;
      oMemWdata   = '0;
      case (r_state)
         S_IDLE: begin
            if (iReq) w_next = w_misal ? S_DONE : S_REQ;
         end
         S_REQ: begin
            oBusy      = 1'b1;
            oMemReq    = 1'b1;
            oMemWrite  = r_write;
            oMemAddr   = {r_addr[31:2], 2'b00};
            oMemByteEn = w_byte_en;
            oMemWdata  = w_wdata;
            if (iMemAck || w_expire) w_next = S_DONE;
         end
         S_DONE: begin
            oBusy       = 1'b1;
            oDone       = 1'b1;
            oMisaligned = r_misal;
            oTimeout    = r_tmo;
            w_next      = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_write     <= 1'b0;
         r_funct3    <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_load_data <= '0;
         r_misal     <= 1'b0;
         r_tmo       <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && iReq) begin
            r_write  <= iWrite;
            r_funct3 <= iFunct3;
            r_addr   <= iAddress;
            r_wdata  <= iWriteData;
            r_cnt    <= '0;
            r_misal  <= w_misal;
            r_tmo    <= 1'b0;
         end
         if (r_state == S_REQ) begin
            r_cnt <= r_cnt + CW'(1);
            if (iMemAck) begin
               if (!r_write) r_load_data <= w_load_val;
            end else if (w_expire) begin
               r_tmo <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Self-checking bench for data_mem_sequencer: transaction-level expectations
// drive a per-cycle compare of every output, pinned by literal load results,
// bus-field literals and REQ-cycle counts.
module tb_data_mem_sequencer;

   localparam int unsigned T = 4;

   logic        iCLK = 1'b0;
   logic        iRST, iReq, iWrite, iMemAck;
   logic [2:0]  iFunct3;
   logic [31:0] iAddress, iWriteData, iMemRdata;
   logic        oBusy, oDone, oMisaligned, oTimeout, oMemReq, oMemWrite;
   logic [31:0] oLoadData, oMemAddr, oMemWdata;
   logic [3:0]  oMemByteEn;

   always #5 iCLK = ~iCLK;

   data_mem_sequencer #(.TIMEOUT_CYCLES(T)) u_dut (
      .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iWrite(iWrite), .iFunct3(iFunct3),
      .iAddress(iAddress), .iWriteData(iWriteData), .oBusy(oBusy), .oDone(oDone),
      .oLoadData(oLoadData), .oMisaligned(oMisaligned), .oTimeout(oTimeout),
      .oMemReq(oMemReq), .oMemWrite(oMemWrite), .oMemAddr(oMemAddr),
      .oMemByteEn(oMemByteEn), .oMemWdata(oMemWdata), .iMemAck(iMemAck),
      .iMemRdata(iMemRdata)
   );

   int n_pass = 0;
   int n_tot  = 0;
   int req_seen = 0;
   bit cmp_en = 1'b0;
   logic [3:0]  last_be;
   logic [31:0] last_wd, last_addr;

   logic        e_busy, e_done, e_mis, e_tmo, e_req, e_wr;
   logic [31:0] e_addr, e_wd, e_ld;
   logic [3:0]  e_be;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic bit f_misal(input logic w, input logic [2:0] f, input logic [31:0] a);
      bit half = (f == 3'b001) || (!w && f == 3'b101);
      return (half && a[0] == 1'b1) || (f == 3'b010 && a % 4 != 0);
   endfunction

   function automatic logic [3:0] f_be(input logic w, input logic [2:0] f, input logic [31:0] a);
      if (!w) return 4'hF;
      case (f)
         3'b000:  return 4'(1 << (a % 4));
         3'b001:  return (a % 4 >= 2) ? 4'hC : 4'h3;
         3'b010:  return 4'hF;
         default: return 4'h0;
      endcase
   endfunction

   function automatic logic [31:0] f_wd(input logic w, input logic [2:0] f, input logic [31:0] d);
      if (w && f == 3'b000) return (d & 32'hFF) * 32'h0101_0101;
      if (w && f == 3'b001) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] f_ld(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * (a % 4))) & 32'hFF;
      h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      case (f)
         3'b000:  return (b >= 32'h80) ? b - 32'h100 : b;
         3'b100:  return b;
         3'b001:  return (h >= 32'h8000) ? h - 32'h1_0000 : h;
         3'b101:  return h;
         3'b010:  return rd;
         default: return 32'h0;
      endcase
   endfunction

   task automatic idle_exp();
      e_busy = 0; e_done = 0; e_mis = 0; e_tmo = 0; e_req = 0; e_wr = 0;
      e_addr = 0; e_wd = 0; e_be = 0;
   endtask

   always @(negedge iCLK) begin
      if (cmp_en) begin
         chk("busy",     oBusy,       e_busy);
         chk("done",     oDone,       e_done);
         chk("misalign", oMisaligned, e_mis);
         chk("timeout",  oTimeout,    e_tmo);
         chk("memreq",   oMemReq,     e_req);
         chk("memwrite", oMemWrite,   e_wr);
         chk("memaddr",  oMemAddr,    e_addr);
         chk("byteen",   oMemByteEn,  e_be);
         chk("wdata",    oMemWdata,   e_wd);
         chk("loaddata", oLoadData,   e_ld);
      end
   end

   always @(negedge iCLK) begin
      if (oMemReq) begin
         req_seen++;
         last_be = oMemByteEn; last_wd = oMemWdata; last_addr = oMemAddr;
      end
   end

   task automatic txn(input logic w, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, input int waits, input logic [31:0] rd,
                      input string tag, input logic [31:0] lit_ld, input int lit_req);
      bit acked = 0;
      iReq = 1; iWrite = w; iFunct3 = f; iAddress = a; iWriteData = d;
      req_seen = 0;
      @(posedge iCLK); #1;
      if (f_misal(w, f, a)) begin
         e_busy = 1; e_done = 1; e_mis = 1;
      end else begin
         e_busy = 1; e_req = 1; e_wr = w; e_addr = a & 32'hFFFF_FFFC;
         e_be = f_be(w, f, a); e_wd = f_wd(w, f, d);
         for (int i = 0; i < 64; i++) begin
            iMemAck   = (i == waits);
            iMemRdata = (i == waits) ? rd : 32'h5A5A_5A5A;
            @(posedge iCLK); #1;
            if (i == waits) begin acked = 1; break; end
            if (i == int'(T) - 1) break;
         end
         iMemAck = 0;
         e_req = 0; e_wr = 0; e_addr = 0; e_be = 0; e_wd = 0;
         e_done = 1; e_tmo = !acked;
         if (acked && !w) e_ld = f_ld(f, a, rd);
      end
      iReq = 0;
      chk({tag, "_ld"}, oLoadData, lit_ld);
      @(posedge iCLK); #1;
      idle_exp();
      chk({tag, "_reqcycles"}, req_seen, lit_req);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      iRST = 1; iReq = 0; iWrite = 0; iFunct3 = 0; iAddress = 0; iWriteData = 0;
      iMemAck = 0; iMemRdata = 0;
      idle_exp(); e_ld = 0;
      @(posedge iCLK); #1;
      cmp_en = 1;
      @(posedge iCLK); #1;
      iRST = 0;

      txn(0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF, "lw",  32'hDEADBEEF, 1);
      txn(0, 3'b000, 32'h103, 0, 0, 32'h80FF0000, "lb",  32'hFFFFFF80, 1);
      txn(0, 3'b100, 32'h103, 0, 0, 32'h80FF0000, "lbu", 32'h00000080, 1);
      txn(0, 3'b001, 32'h102, 0, 0, 32'h80FF0000, "lh",  32'hFFFF80FF, 1);
      txn(0, 3'b101, 32'h102, 0, 0, 32'h80FF0000, "lhu", 32'h000080FF, 1);

      txn(1, 3'b000, 32'h201, 32'h000000AB, 3, 0, "sb", 32'h000080FF, 4);
      chk("sb_be",   last_be,   4'b0010);
      chk("sb_wd",   last_wd,   32'hABABABAB);
      chk("sb_addr", last_addr, 32'h200);
      txn(1, 3'b001, 32'h202, 32'h1234ABCD, 1, 0, "sh", 32'h000080FF, 2);
      chk("sh_be", last_be, 4'b1100);
      chk("sh_wd", last_wd, 32'hABCDABCD);
      txn(1, 3'b010, 32'h20C, 32'hCAFEF00D, 0, 0, "sw", 32'h000080FF, 1);
      chk("sw_be", last_be, 4'b1111);

      txn(0, 3'b010, 32'h102, 0, 0, 0, "lw_mis", 32'h000080FF, 0);
      txn(1, 3'b001, 32'h101, 32'h5555, 0, 0, "sh_mis", 32'h000080FF, 0);
      txn(0, 3'b000, 32'h101, 0, 2, 32'h00007F00, "lb_wait", 32'h0000007F, 3);

      txn(0, 3'b010, 32'h300, 0, 1000, 0, "lw_tmo", 32'h0000007F, 4);

      txn(0, 3'b011, 32'h104, 0, 0, 32'hFFFFFFFF, "ld_bad", 32'h00000000, 1);
      txn(1, 3'b100, 32'h208, 32'h11223344, 0, 0, "st_bad", 32'h00000000, 1);
      chk("st_bad_be", last_be, 4'b0000);

      // reset while the bus request is outstanding
      txn(0, 3'b010, 32'h108, 0, 0, 32'h0BADF00D, "lw_pre", 32'h0BADF00D, 1);
      iReq = 1; iWrite = 0; iFunct3 = 3'b010; iAddress = 32'h400;
      @(posedge iCLK); #1;
      e_busy = 1; e_req = 1; e_addr = 32'h400; e_be = 4'hF;
      iReq = 0;
      chk("rst_pre_req", oMemReq, 1);
      iRST = 1;
      @(posedge iCLK); #1;
      iRST = 0;
      idle_exp(); e_ld = 0;
      chk("rst_memreq", oMemReq, 0);
      chk("rst_busy",   oBusy,   0);
      chk("rst_ld",     oLoadData, 0);
      @(posedge iCLK); #1;
      txn(0, 3'b010, 32'h404, 0, 0, 32'h12345678, "lw_post", 32'h12345678, 1);

      @(posedge iCLK); #1;
      cmp_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
